// File: rtl/score_reporter_pkg.sv
// Shared message kinds, lengths and byte helpers for the score reporter.
package score_reporter_pkg;

    typedef enum logic [1:0] {
        MSG_GO    = 2'd0,
        MSG_SCORE = 2'd1,
        MSG_END   = 2'd2
    } msg_kind_e;

    localparam int unsigned GO_LEN    = 4;
    localparam int unsigned SCORE_LEN = 8;
    localparam int unsigned END_LEN   = 10;
    localparam int unsigned IDX_W     = 4;

    function automatic logic [IDX_W-1:0] msg_last(input msg_kind_e kind);
        case (kind)
            MSG_GO:    return IDX_W'(GO_LEN - 1);
            MSG_SCORE: return IDX_W'(SCORE_LEN - 1);
            default:   return IDX_W'(END_LEN - 1);
        endcase
    endfunction

    // Non-decimal nibbles print as '?'.
    function automatic logic [7:0] digit_byte(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : 8'h3F;
    endfunction

endpackage

// File: rtl/score_reporter_tx_msg_rom.sv
// Combinational byte lookup: message kind, byte index and score snapshot to ASCII.
module tx_msg_rom
    import score_reporter_pkg::*;
(
    input  logic [1:0]       kind,
    input  logic [IDX_W-1:0] idx,
    input  logic [15:0]      snap,
    output logic [7:0]       byte_c
);

    always_comb begin
        byte_c = 8'h00;
        case (msg_kind_e'(kind))
            MSG_GO: begin
                case (idx)
                    4'd0:    byte_c = 8'h47;
                    4'd1:    byte_c = 8'h4F;
                    4'd2:    byte_c = 8'h0D;
                    4'd3:    byte_c = 8'h0A;
                    default: byte_c = 8'h00;
                endcase
            end
            MSG_SCORE: begin
                case (idx)
                    4'd0:    byte_c = 8'h53;
                    4'd1:    byte_c = 8'h3D;
                    4'd2:    byte_c = digit_byte(snap[15:12]);
                    4'd3:    byte_c = digit_byte(snap[11:8]);
                    4'd4:    byte_c = digit_byte(snap[7:4]);
                    4'd5:    byte_c = digit_byte(snap[3:0]);
                    4'd6:    byte_c = 8'h0D;
                    4'd7:    byte_c = 8'h0A;
                    default: byte_c = 8'h00;
                endcase
            end
            MSG_END: begin
                case (idx)
                    4'd0:    byte_c = 8'h45;
                    4'd1:    byte_c = 8'h4E;
                    4'd2:    byte_c = 8'h44;
                    4'd3:    byte_c = 8'h20;
                    4'd4:    byte_c = digit_byte(snap[15:12]);
                    4'd5:    byte_c = digit_byte(snap[11:8]);
                    4'd6:    byte_c = digit_byte(snap[7:4]);
                    4'd7:    byte_c = digit_byte(snap[3:0]);
                    4'd8:    byte_c = 8'h0D;
                    4'd9:    byte_c = 8'h0A;
                    default: byte_c = 8'h00;
                endcase
            end
            default: byte_c = 8'h00;
        endcase
    end

endmodule

// File: rtl/score_reporter.sv
// Turns game events into ASCII status messages pushed one byte at a time to a UART.
module score_reporter
    import score_reporter_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        over,
    input  logic [15:0] score,
    input  logic        score_inc,
    input  logic        is_transmitting,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic        busy
);

    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_e;

    state_e           state, state_d;
    msg_kind_e        kind, kind_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [15:0]      snap, snap_d;
    logic [TMR_W-1:0] timer, timer_d;
    logic             pend_go, pend_end, pend_score;
    logic             clr_go, clr_end, clr_score;
    logic             start_q, over_q, armed;
    logic             start_rise, over_rise;
    logic             transmit_d, busy_d, advance, timeout;
    logic [7:0]       tx_byte_d, rom_byte;

    tx_msg_rom u_rom (
        .kind   (kind),
        .idx    (idx),
        .snap   (snap),
        .byte_c (rom_byte)
    );

    // armed stays low for the first cycle after reset so levels already high are not edges
    assign start_rise = armed & start & ~start_q;
    assign over_rise  = armed & over & ~over_q;
    assign timeout    = (timer == TMR_W'(BUSY_TIMEOUT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            kind       <= MSG_GO;
            idx        <= '0;
            snap       <= '0;
            timer      <= '0;
            pend_go    <= 1'b0;
            pend_end   <= 1'b0;
            pend_score <= 1'b0;
            start_q    <= 1'b0;
            over_q     <= 1'b0;
            armed      <= 1'b0;
            transmit   <= 1'b0;
            tx_byte    <= 8'h00;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            kind       <= kind_d;
            idx        <= idx_d;
            snap       <= snap_d;
            timer      <= timer_d;
            pend_go    <= (pend_go & ~clr_go) | start_rise;
            pend_end   <= (pend_end & ~clr_end) | over_rise;
            pend_score <= (pend_score & ~clr_score) | score_inc;
            start_q    <= start;
            over_q     <= over;
            armed      <= 1'b1;
            transmit   <= transmit_d;
            tx_byte    <= tx_byte_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d    = state;
        kind_d     = kind;
        idx_d      = idx;
        snap_d     = snap;
        clr_go     = 1'b0;
        clr_end    = 1'b0;
        clr_score  = 1'b0;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte;
        advance    = 1'b0;

        case (state)
            IDLE: begin
                if (pend_end || pend_go || pend_score) begin
                    idx_d   = '0;
                    state_d = SEND;
                    if (pend_end) begin
                        kind_d    = MSG_END;
                        snap_d    = score;
                        clr_end   = 1'b1;
                        clr_go    = 1'b1;
                        clr_score = 1'b1;
                    end else if (pend_go) begin
                        kind_d = MSG_GO;
                        clr_go = 1'b1;
                    end else begin
                        kind_d    = MSG_SCORE;
                        snap_d    = score;
                        clr_score = 1'b1;
                    end
                end
            end
            SEND: begin
                if (!is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = rom_byte;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (is_transmitting) state_d = WAIT_DONE;
                else if (timeout)    advance = 1'b1;
            end
            WAIT_DONE: begin
                if (!is_transmitting || timeout) advance = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A timed-out byte is treated exactly like a completed one
        if (advance) begin
            if (idx == msg_last(kind)) begin
                state_d = IDLE;
            end else begin
                idx_d   = idx + IDX_W'(1);
                state_d = SEND;
            end
        end

        if (state_d != state)
            timer_d = '0;
        else if (state == WAIT_BUSY || state == WAIT_DONE)
            timer_d = timer + TMR_W'(1);
        else
            timer_d = '0;

        busy_d = (state_d != IDLE);
    end

endmodule
